// File: rtl/lsu_issue_arbiter_if.sv
// LSU issue arbiter port bundle: AGEN lanes, replay offer and issued ld/st slots.
// master drives AGEN/replay requests; slave is the arbiter, which returns grants and issued ops.
interface lsu_issue_arbiter_if #(
  parameter int NUM_AGEN     = 2,
  parameter int PKT_W        = 128,
  parameter int REPLAY_DEPTH = 4
);
  localparam int cntW = $clog2(REPLAY_DEPTH) + 1;

  logic                      recoverFlag_i;
  logic [NUM_AGEN-1:0]       agenValid_i;
  logic [NUM_AGEN-1:0]       agenIsLoad_i;
  logic [NUM_AGEN*PKT_W-1:0] agenPkt_i;
  logic [NUM_AGEN-1:0]       agenReady_o;
  logic                      replayValid_i;
  logic [PKT_W-1:0]          replayPkt_i;
  logic                      replayReady_o;
  logic [cntW-1:0]           replayCount_o;
  logic                      ldValid_o;
  logic [PKT_W-1:0]          ldPkt_o;
  logic                      ldFromReplay_o;
  logic                      stValid_o;
  logic [PKT_W-1:0]          stPkt_o;

  modport master (
    output recoverFlag_i, agenValid_i, agenIsLoad_i, agenPkt_i,
    output replayValid_i, replayPkt_i,
    input  agenReady_o, replayReady_o, replayCount_o,
    input  ldValid_o, ldPkt_o, ldFromReplay_o, stValid_o, stPkt_o
  );

  modport slave (
    input  recoverFlag_i, agenValid_i, agenIsLoad_i, agenPkt_i,
    input  replayValid_i, replayPkt_i,
    output agenReady_o, replayReady_o, replayCount_o,
    output ldValid_o, ldPkt_o, ldFromReplay_o, stValid_o, stPkt_o
  );
endinterface

// File: rtl/lsu_issue_arbiter.sv
// Picks one load and one store per cycle from AGEN lanes plus a replay FIFO; 1-cycle registered issue.
// Ungranted lanes see agenReady_o=0 and hold; replay offers are refused while the FIFO count is full.
module lsu_issue_arbiter #(
  parameter int NUM_AGEN     = 2,
  parameter int PKT_W        = 128,
  parameter int REPLAY_DEPTH = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic               clk,
  input logic               reset,
  lsu_issue_arbiter_if.slave bus
);
  localparam int ptrW    = $clog2(REPLAY_DEPTH);
  localparam int cntW    = ptrW + 1;
  localparam int starveW = $clog2(STARVE_LIMIT + 1);

  logic [PKT_W-1:0]   fifoMem [REPLAY_DEPTH];
  logic [ptrW-1:0]    rdPtr;
  logic [ptrW-1:0]    wrPtr;
  logic [cntW-1:0]    count;
  logic [cntW-1:0]    countNext;
  logic [starveW-1:0] starve;

  logic                fifoEmpty;
  logic                aged;
  logic                stAny;
  logic                ldAny;
  logic                ldTakeLane;
  logic                deq;
  logic                enq;
  logic [NUM_AGEN-1:0] stHot;
  logic [NUM_AGEN-1:0] ldHot;
  logic [PKT_W-1:0]    stLanePkt;
  logic [PKT_W-1:0]    ldLanePkt;

  // Lowest-index priority pick, independently for the store and load slots.
  always_comb begin
    stHot     = '0;
    ldHot     = '0;
    stAny     = 1'b0;
    ldAny     = 1'b0;
    stLanePkt = '0;
    ldLanePkt = '0;
    for (int i = 0; i < NUM_AGEN; i++) begin
      if (bus.agenValid_i[i] && !bus.agenIsLoad_i[i] && !stAny) begin
        stHot[i]  = 1'b1;
        stAny     = 1'b1;
        stLanePkt = bus.agenPkt_i[i*PKT_W +: PKT_W];
      end
      if (bus.agenValid_i[i] && bus.agenIsLoad_i[i] && !ldAny) begin
        ldHot[i]  = 1'b1;
        ldAny     = 1'b1;
        ldLanePkt = bus.agenPkt_i[i*PKT_W +: PKT_W];
      end
    end
  end

  assign fifoEmpty  = (count == '0);
  assign aged       = !fifoEmpty && (starve == starveW'(STARVE_LIMIT));
  assign ldTakeLane = !bus.recoverFlag_i && ldAny && !aged;
  // The replay head issues whenever the load slot is not claimed by a lane.
  assign deq        = !bus.recoverFlag_i && !fifoEmpty && !(ldAny && !aged);
  assign enq        = !bus.recoverFlag_i && bus.replayValid_i && bus.replayReady_o;

  assign bus.agenReady_o   = bus.recoverFlag_i ? '0 : (stHot | (ldTakeLane ? ldHot : '0));
  assign bus.replayCount_o = count;

  always_comb begin
    countNext = count;
    if (enq && !deq) begin
      countNext = count + cntW'(1);
    end else if (deq && !enq) begin
      countNext = count - cntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifoMem[wrPtr] <= bus.replayPkt_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr              <= '0;
      wrPtr              <= '0;
      count              <= '0;
      starve             <= '0;
      bus.replayReady_o  <= 1'b1;
      bus.ldValid_o      <= 1'b0;
      bus.ldPkt_o        <= '0;
      bus.ldFromReplay_o <= 1'b0;
      bus.stValid_o      <= 1'b0;
      bus.stPkt_o        <= '0;
    end else if (bus.recoverFlag_i) begin
      rdPtr              <= '0;
      wrPtr              <= '0;
      count              <= '0;
      starve             <= '0;
      bus.replayReady_o  <= 1'b1;
      bus.ldValid_o      <= 1'b0;
      bus.ldPkt_o        <= '0;
      bus.ldFromReplay_o <= 1'b0;
      bus.stValid_o      <= 1'b0;
      bus.stPkt_o        <= '0;
    end else begin
      if (enq) begin
        wrPtr <= wrPtr + ptrW'(1);
      end
      if (deq) begin
        rdPtr <= rdPtr + ptrW'(1);
      end
      count             <= countNext;
      bus.replayReady_o <= (countNext < cntW'(REPLAY_DEPTH));

      // Aging restarts for every new head, and never counts while the FIFO is empty.
      if (fifoEmpty || deq) begin
        starve <= '0;
      end else if (starve != starveW'(STARVE_LIMIT)) begin
        starve <= starve + starveW'(1);
      end

      bus.stValid_o      <= stAny;
      bus.stPkt_o        <= stLanePkt;
      bus.ldValid_o      <= ldTakeLane || deq;
      bus.ldFromReplay_o <= deq;
      bus.ldPkt_o        <= deq ? fifoMem[rdPtr] : (ldTakeLane ? ldLanePkt : '0);
    end
  end
endmodule
